// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter
// Round-robin arbiter that shares one Avalon MM slave between NUM_MASTERS
// masters. The owner keeps the grant for a release window after its
// chipselect drops, so late read data still reaches it. A watchdog takes the
// bus back from an owner that stays in GRANT too long.
module avalon_mm_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int ADDR_SIZE    = 32,
    parameter int DATA_SIZE    = 32,
    parameter int RELEASE_HOLD = 4,
    parameter int MAX_HOLD     = 1024
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [NUM_MASTERS-1:0]                                m_chipselect,
    input  logic [NUM_MASTERS-1:0]                                m_read,
    input  logic [NUM_MASTERS-1:0]                                m_write,
    input  logic [NUM_MASTERS*ADDR_SIZE-1:0]                      m_address,
    input  logic [NUM_MASTERS*DATA_SIZE-1:0]                      m_writedata,
    output logic [NUM_MASTERS*DATA_SIZE-1:0]                      m_readdata,
    output logic [NUM_MASTERS-1:0]                                m_grant,
    output logic                                                  s_chipselect,
    output logic                                                  s_read,
    output logic                                                  s_write,
    output logic [ADDR_SIZE-1:0]                                  s_address,
    output logic [DATA_SIZE-1:0]                                  s_writedata,
    input  logic [DATA_SIZE-1:0]                                  s_readdata,
    output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] owner,
    output logic                                                  busy,
    output logic                                                  err_timeout
);

    localparam int OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [OWNER_W:0]       NUM_M_W     = (OWNER_W + 1)'(NUM_MASTERS);
    localparam logic [OWNER_W-1:0]     LAST_IDX    = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [15:0]            MAX_HOLD_M1 = 16'(MAX_HOLD - 1);
    localparam logic [7:0]             REL_LOAD    = 8'(RELEASE_HOLD);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0    = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]             rel_cnt_q, rel_cnt_d;
    logic [15:0]            hold_cnt_q, hold_cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic                   pick_valid_s;
    logic [OWNER_W-1:0]     pick_idx_s;
    logic                   own_cs_s;
    logic                   own_rd_s;
    logic                   own_wr_s;
    logic [ADDR_SIZE-1:0]   own_addr_s;
    logic [DATA_SIZE-1:0]   own_wdata_s;
    logic                   busy_s;
    logic                   err_timeout_s;

    // Round-robin successor of an index, wrapping the last master back to 0.
    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] v);
        logic [OWNER_W-1:0] r;
        r = (v == LAST_IDX) ? '0 : v + OWNER_W'(1);
        return r;
    endfunction

    assign busy_s        = (state_q != ST_IDLE);
    assign err_timeout_s = (state_q == ST_GRANT) && (hold_cnt_q == MAX_HOLD_M1);

    // Find the first requester at or after rr_ptr, modulo NUM_MASTERS.
    always_comb begin
        logic [OWNER_W:0] sum_v;
        logic             hit_v;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        sum_v        = '0;
        hit_v        = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            sum_v        = {1'b0, rr_ptr_q} + (OWNER_W + 1)'(k);
            sum_v        = (sum_v >= NUM_M_W) ? (sum_v - NUM_M_W) : sum_v;
            hit_v        = !pick_valid_s && m_chipselect[sum_v[OWNER_W-1:0]];
            pick_idx_s   = hit_v ? sum_v[OWNER_W-1:0] : pick_idx_s;
            pick_valid_s = pick_valid_s | hit_v;
        end
    end

    // Select the current owner's request signals; other masters are ignored.
    always_comb begin
        own_cs_s    = 1'b0;
        own_rd_s    = 1'b0;
        own_wr_s    = 1'b0;
        own_addr_s  = '0;
        own_wdata_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            own_cs_s    = own_cs_s | ((owner_q == OWNER_W'(i)) & m_chipselect[i]);
            own_rd_s    = own_rd_s | ((owner_q == OWNER_W'(i)) & m_read[i]);
            own_wr_s    = own_wr_s | ((owner_q == OWNER_W'(i)) & m_write[i]);
            own_addr_s  = own_addr_s |
                          ({ADDR_SIZE{owner_q == OWNER_W'(i)}} & m_address[i*ADDR_SIZE +: ADDR_SIZE]);
            own_wdata_s = own_wdata_s |
                          ({DATA_SIZE{owner_q == OWNER_W'(i)}} & m_writedata[i*DATA_SIZE +: DATA_SIZE]);
        end
    end

    // Next-state logic for the IDLE / GRANT / RELEASE controller.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        rel_cnt_d  = rel_cnt_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    owner_d    = pick_idx_s;
                    grant_d    = ONE_HOT0 << pick_idx_s;
                    hold_cnt_d = 16'd0;
                    state_d    = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = hold_cnt_q + 16'd1;
                if (err_timeout_s) begin
                    // Watchdog wins over a simultaneous release.
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = wrap_inc(owner_q);
                end else if (!own_cs_s) begin
                    if (RELEASE_HOLD == 0) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = wrap_inc(owner_q);
                    end else begin
                        rel_cnt_d = REL_LOAD;
                        state_d   = ST_RELEASE;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                if (own_cs_s) begin
                    // Owner resumes; hold_cnt keeps counting from where it was.
                    state_d = ST_GRANT;
                end else if (rel_cnt_q == 8'd1) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = wrap_inc(owner_q);
                end else begin
                    rel_cnt_d = rel_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Controller registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            rel_cnt_q  <= 8'd0;
            hold_cnt_q <= 16'd0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            rel_cnt_q  <= rel_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
        end
    end

    // Slave port: forward the owner only while in GRANT, otherwise drive zeros.
    always_comb begin
        s_chipselect = 1'b0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        if (state_q == ST_GRANT) begin
            s_chipselect = own_cs_s;
            s_read       = own_rd_s;
            s_write      = own_wr_s;
            s_address    = own_addr_s;
            s_writedata  = own_wdata_s;
        end else begin
            s_chipselect = 1'b0;
            s_read       = 1'b0;
            s_write      = 1'b0;
            s_address    = '0;
            s_writedata  = '0;
        end
    end

    // Return slave read data to the owner's slice only while the bus is held.
    always_comb begin
        m_readdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_readdata[i*DATA_SIZE +: DATA_SIZE] =
                (busy_s && (owner_q == OWNER_W'(i))) ? s_readdata : '0;
        end
    end

    assign m_grant     = grant_q;
    assign owner       = owner_q;
    assign busy        = busy_s;
    assign err_timeout = err_timeout_s;

endmodule
